// File: rtl/coa_pkg.sv
// rtl/coa_pkg.sv - shared COA pipeline constants and checker state encoding
package coa_pkg;

    localparam int COA_D_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        END  = 2'd2
    } coa_state_t;

endpackage

// File: rtl/coa_sync_fifo.sv
// rtl/coa_sync_fifo.sv - single-clock FIFO with registered head, used for the expected stream
module coa_sync_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_d,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] head
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [AW:0]       count;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count = wr_ptr - rd_ptr;
    assign full  = count[AW];
    assign empty = (count == '0);
    assign head  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_d;
        end
    end

endmodule

// File: rtl/coa_result_checker.sv
// rtl/coa_result_checker.sv - scores the COA result stream against a buffered expected stream
module coa_result_checker
    import coa_pkg::*;
#(
    parameter int DATA_W     = COA_D_W,
    parameter int DEPTH      = 16,
    parameter int N_RESULTS  = 1000,
    parameter int MAX_CYCLES = 10000,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_d,
    input  logic              exp_valid,
    input  logic [DATA_W-1:0] exp_d,
    output logic              exp_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              pass,
    output logic              underrun,
    output logic [CNT_W-1:0]  rx_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  first_err_idx,
    output logic [DATA_W-1:0] first_err_d,
    output logic [DATA_W-1:0] first_err_exp
);

    localparam logic [CNT_W-1:0] N_LAST   = CNT_W'(N_RESULTS);
    localparam logic [CNT_W-1:0] CYC_LAST = CNT_W'(MAX_CYCLES - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    coa_state_t        state;
    coa_state_t        state_nxt;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_head;
    logic              start_run;
    logic              accept;
    logic              is_err;
    logic              complete;
    logic              cyc_limit;

    assign start_run = start && (state != RUN);
    assign accept    = (state == RUN) && res_valid;
    assign is_err    = accept && (fifo_empty || (res_d != fifo_head));
    assign complete  = accept && (sat_inc(rx_cnt) == N_LAST);
    assign cyc_limit = (state == RUN) && (cycle_cnt == CYC_LAST);

    assign exp_ready = !fifo_full;
    assign busy      = (state == RUN);
    assign pass      = done && (err_cnt == '0) && !underrun;

    coa_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_exp_fifo (
        .clk    (clk),
        .rst_n  (rst_n),
        .push   (exp_valid),
        .push_d (exp_d),
        .pop    (accept),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .head   (fifo_head)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Completion is checked before the cycle budget so done wins a tie.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, END: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (complete || cyc_limit) begin
                    state_nxt = END;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done          <= 1'b0;
            timeout       <= 1'b0;
            underrun      <= 1'b0;
            rx_cnt        <= '0;
            err_cnt       <= '0;
            cycle_cnt     <= '0;
            first_err_idx <= '0;
            first_err_d   <= '0;
            first_err_exp <= '0;
        end else if (start_run) begin
            done          <= 1'b0;
            timeout       <= 1'b0;
            underrun      <= 1'b0;
            rx_cnt        <= '0;
            err_cnt       <= '0;
            cycle_cnt     <= '0;
            first_err_idx <= '0;
            first_err_d   <= '0;
            first_err_exp <= '0;
        end else if (state == RUN) begin
            cycle_cnt <= sat_inc(cycle_cnt);
            if (accept) begin
                rx_cnt <= sat_inc(rx_cnt);
            end
            if (is_err) begin
                err_cnt <= sat_inc(err_cnt);
                if (fifo_empty) begin
                    underrun <= 1'b1;
                end
                if (err_cnt == '0) begin
                    first_err_idx <= rx_cnt;
                    first_err_d   <= res_d;
                    first_err_exp <= fifo_empty ? '0 : fifo_head;
                end
            end
            if (complete) begin
                done <= 1'b1;
            end else if (cyc_limit) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: doc/coa_result_checker.md
# coa_result_checker

Synthesizable response checker for the COA pipeline's result stream. It sits at the consumer end of the COA interface and accepts one D word per cycle whenever valid_out is high. Each result is compared in order against a buffered stream of expected answers. The block counts results, errors and elapsed cycles, and flags completion or timeout, so a COA run can be scored in hardware or in FPGA bring-up without a simulation bench.

## Interface
Parameters:
- DATA_W, 10, width of result and expected words (COA D width)
- DEPTH, 16, expected-value FIFO depth; power of two, ≥2
- N_RESULTS, 1000, results per run
- MAX_CYCLES, 10000, run cycle budget before timeout
- CNT_W, 16, width of all counters; must hold max(N_RESULTS, MAX_CYCLES)

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a run
- res_valid  in  1  result strobe (connect to COA valid_out)
- res_d  in  DATA_W  result word (connect to COA D)
- exp_valid  in  1  expected-word strobe
- exp_d  in  DATA_W  expected word
- exp_ready  out  1  FIFO not full; a push occurs on exp_valid && exp_ready
- busy  out  1  state == RUN
- done  out  1  sticky; N_RESULTS results received
- timeout  out  1  sticky; budget exhausted first
- pass  out  1  done && err_cnt == 0 && !underrun
- underrun  out  1  sticky; a result arrived while the FIFO was empty
- rx_cnt  out  CNT_W  results accepted this run
- err_cnt  out  CNT_W  mismatches, including underruns
- cycle_cnt  out  CNT_W  cycles spent in RUN
- first_err_idx  out  CNT_W  rx index of the first error
- first_err_d  out  DATA_W  res_d at the first error
- first_err_exp  out  DATA_W  expected word at the first error (0 if underrun)

## Operation
- Reset: FSM goes to IDLE, FIFO is empty, every output is 0 except exp_ready = 1.
- FSM has three states: IDLE, RUN, END.
  - IDLE or END with start: go to RUN; clear counters, done, timeout, underrun and first_err_*. The FIFO is not flushed.
  - RUN with start: start is ignored.
  - RUN to END when the accepted result makes rx_cnt reach N_RESULTS. Set done.
  - RUN to END when cycle_cnt reaches MAX_CYCLES − 1 with no completion. Set timeout.
  - If completion and the timeout limit occur in the same cycle, done wins and timeout stays 0.
- Expected FIFO:
  - It accepts pushes in every state.
  - It pops one word for each result accepted in RUN while not empty.
  - exp_ready = count < DEPTH.
  - There is no bypass: a push and a result in the same cycle with the FIFO empty is an underrun, and the pushed word is stored.
- Each result accepted in RUN:
  - rx_cnt increments.
  - If res_d ≠ FIFO head, err_cnt increments. If the FIFO is empty, err_cnt increments and underrun is set.
  - If this is the first error, capture first_err_* using the pre-increment rx_cnt as the index.
- res_valid outside RUN is ignored: no pop, no count.
- Counters saturate at 2^CNT_W − 1.

## Timing
- Every output is registered, with one cycle of latency. A result sampled on edge k is reflected in rx_cnt, err_cnt and first_err_* after edge k.
- done or timeout rises on the same edge that moves the FSM to END. busy falls on that edge.
- cycle_cnt increments on every edge while in RUN, including the edge that leaves RUN.
- A start sampled on edge k makes busy = 1 after edge k. A result present at edge k+1 is the first one counted.
- Full throughput: one result and one push per cycle are sustained indefinitely while the FIFO is non-empty and not full.
- Asserting rst_n low mid-run clears everything immediately, without waiting for clk.

## Structure
- Package coa_pkg: COA_D_W = 10 and the FSM state enum {IDLE, RUN, END}. The COA block and this checker share the package.
- One sub-module, coa_sync_fifo: parameterized DATA_W/DEPTH, push/pop/full/empty/head, async active-low reset. The checker instantiates it for the expected stream.

## Test plan
- All match: N_RESULTS=4, preload 5,10,15,20, start, results 5,10,15,20 back-to-back. Require done=1 and pass=1, err_cnt=0 and rx_cnt=4, and cycle_cnt=4.
- Mismatch: same setup with results 5,11,15,19. Require err_cnt=2, first_err_idx=1, first_err_d=11, first_err_exp=10, pass=0.
- Underrun: preload 1 word (7), start, results 7,8. Require underrun=1 and err_cnt=1, first_err_idx=1 and first_err_exp=0.
- Timeout: MAX_CYCLES=8, N_RESULTS=4, only 2 results sent. Require timeout=1 after the 8th RUN cycle, done=0, cycle_cnt=8.
- FIFO full: DEPTH=4, hold exp_valid with 6 words and no results. Require exp_ready=0 after 4 pushes, only 4 words stored, and exp_ready=1 one cycle after the first pop.
- Reset and restart: assert rst_n low mid-run, then check that all outputs are 0 and exp_ready=1 before the next clk edge. Then start in END clears counters and keeps the FIFO contents.
